// File: rtl/magic_trigger_if.sv
// Signal bundle between the button/hotkey front end, the magic trigger
// sequencer and the magic/NMI block. The sequencer uses the master side.
interface magic_trigger_if;
  logic button_raw;
  logic hotkey_req;
  logic frame_tick;
  logic magic_mode;
  logic magic_button;
  logic reset_req;
  logic nmi_timeout;
  logic busy;

  modport master (
    input  button_raw, hotkey_req, frame_tick, magic_mode,
    output magic_button, reset_req, nmi_timeout, busy
  );

  modport slave (
    output button_raw, hotkey_req, frame_tick, magic_mode,
    input  magic_button, reset_req, nmi_timeout, busy
  );
endinterface

// File: rtl/magic_trigger.sv
// Magic button sequencer: synchronizes and debounces the raw button, merges
// it with hotkey requests, holds magic_button until the magic block answers
// with magic_mode, aborts unanswered requests after a frame budget and turns
// a long press inside magic mode into a one-cycle reset request.
module magic_trigger #(
  parameter int DEBOUNCE_CYCLES    = 280000,
  parameter int LONG_PRESS_FRAMES  = 100,
  parameter int NMI_TIMEOUT_FRAMES = 4
) (
  input  logic           clk28,
  input  logic           rst,
  magic_trigger_if.master bus
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FR_MAX = (LONG_PRESS_FRAMES > NMI_TIMEOUT_FRAMES) ?
                          LONG_PRESS_FRAMES : NMI_TIMEOUT_FRAMES;
  localparam int FR_W   = $clog2(FR_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FR_W-1:0] LP_LAST = FR_W'(LONG_PRESS_FRAMES - 1);
  localparam logic [FR_W-1:0] TO_LAST = FR_W'(NMI_TIMEOUT_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            sync_p0;
  logic            btn_s;
  logic            btn_db;
  logic            btn_db_d;
  logic            press;
  logic            trig;
  logic [DB_W-1:0] db_cnt;
  logic [FR_W-1:0] frame_cnt;
  logic            reset_req_nxt;
  logic            nmi_timeout_nxt;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk28) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_p0 <= bus.button_raw;
      btn_s   <= sync_p0;
    end
  end

  // Debouncer: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk28) begin
    if (rst) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Registered one-cycle pulse on each debounced press
  always_ff @(posedge clk28) begin
    if (rst) begin
      btn_db_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      press    <= btn_db & ~btn_db_d;
    end
  end

  // Shared frame counter, restarted on every state change
  always_ff @(posedge clk28) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (state_nxt != state) begin
      frame_cnt <= '0;
    end else if (bus.frame_tick) begin
      frame_cnt <= frame_cnt + FR_W'(1);
    end
  end

  // Next-state and pulse decode; magic_mode wins over a coincident timeout tick
  always_comb begin
    state_nxt       = state;
    reset_req_nxt   = 1'b0;
    nmi_timeout_nxt = 1'b0;
    trig            = press | bus.hotkey_req;
    case (state)
      ST_IDLE: begin
        if (trig) begin
          state_nxt = bus.magic_mode ? ST_HOLD : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.magic_mode) begin
          state_nxt = ST_HOLD;
        end else if (bus.frame_tick && (frame_cnt == TO_LAST)) begin
          state_nxt       = ST_IDLE;
          nmi_timeout_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!btn_db) begin
          state_nxt = ST_IDLE;
        end else if (bus.frame_tick && (frame_cnt == LP_LAST)) begin
          state_nxt     = ST_RELEASE;
          reset_req_nxt = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!btn_db) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk28) begin
    if (rst) begin
      state            <= ST_IDLE;
      bus.magic_button <= 1'b0;
      bus.reset_req    <= 1'b0;
      bus.nmi_timeout  <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      state            <= state_nxt;
      bus.magic_button <= (state_nxt == ST_REQ);
      bus.reset_req    <= reset_req_nxt;
      bus.nmi_timeout  <= nmi_timeout_nxt;
      bus.busy         <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_magic_trigger.sv
// Bench for magic_trigger with small debounce/frame parameters: directed
// scenarios plus randomized traffic, compared cycle by cycle against a
// behavioural model of the sequencer.
module tb_magic_trigger;

  localparam int DC = 8;
  localparam int LP = 3;
  localparam int TO = 2;

  logic clk28 = 1'b0;
  logic rst   = 1'b1;

  magic_trigger_if bus ();

  magic_trigger #(
    .DEBOUNCE_CYCLES   (DC),
    .LONG_PRESS_FRAMES (LP),
    .NMI_TIMEOUT_FRAMES(TO)
  ) dut (
    .clk28(clk28),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk28 = ~clk28;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model. Raw samples are kept in a short history; the
  // debounced level flips once the last DC synchronized samples all
  // disagree with it. A press is usable as a trigger two edges after the
  // debounced level rises. States are plain ints; m_ticks counts frame
  // ticks seen since the current state was entered.
  // ---------------------------------------------------------------------
  localparam int M_IDLE = 0, M_REQ = 1, M_HOLD = 2, M_REL = 3;

  bit raw_q[$];
  bit s_q[$];
  int m_cyc;
  int m_rise;
  bit m_db;
  int m_state;
  int m_ticks;
  bit m_mb, m_rr, m_nt, m_busy;

  always @(posedge clk28) begin : model
    bit btn_s, trig, all_diff;
    int nxt;
    if (rst) begin
      raw_q.delete();
      s_q.delete();
      m_cyc   = 0;
      m_rise  = -100;
      m_db    = 1'b0;
      m_state = M_IDLE;
      m_ticks = 0;
      m_mb    = 1'b0;
      m_rr    = 1'b0;
      m_nt    = 1'b0;
      m_busy  = 1'b0;
    end else begin
      m_cyc++;
      trig = (m_rise == m_cyc - 2) || bus.hotkey_req;
      nxt  = m_state;
      m_rr = 1'b0;
      m_nt = 1'b0;
      case (m_state)
        M_IDLE: if (trig) nxt = bus.magic_mode ? M_HOLD : M_REQ;
        M_REQ: begin
          if (bus.magic_mode) nxt = M_HOLD;
          else if (bus.frame_tick && m_ticks == TO - 1) begin nxt = M_IDLE; m_nt = 1'b1; end
        end
        M_HOLD: begin
          if (!m_db) nxt = M_IDLE;
          else if (bus.frame_tick && m_ticks == LP - 1) begin nxt = M_REL; m_rr = 1'b1; end
        end
        default: if (!m_db) nxt = M_IDLE;
      endcase
      if (nxt != m_state) m_ticks = 0;
      else if (bus.frame_tick) m_ticks++;
      m_state = nxt;
      m_mb    = (nxt == M_REQ);
      m_busy  = (nxt != M_IDLE);

      btn_s = (raw_q.size() >= 2) ? raw_q[1] : 1'b0;
      s_q.push_front(btn_s);
      if (s_q.size() > DC) void'(s_q.pop_back());
      all_diff = (s_q.size() == DC);
      foreach (s_q[i]) if (s_q[i] == m_db) all_diff = 1'b0;
      if (all_diff) begin
        m_db = ~m_db;
        if (m_db) m_rise = m_cyc;
        s_q.delete();
      end
      raw_q.push_front(bus.button_raw);
      if (raw_q.size() > 2) void'(raw_q.pop_back());
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  bit chk_en = 1'b0;
  int rr_seen = 0;
  int nt_seen = 0;

  always @(negedge clk28) begin
    if (chk_en) begin
      check_eq("magic_button", bus.magic_button, m_mb);
      check_eq("reset_req", bus.reset_req, m_rr);
      check_eq("nmi_timeout", bus.nmi_timeout, m_nt);
      check_eq("busy", bus.busy, m_busy);
      check_eq("btn_db", dut.btn_db, m_db);
      if (bus.reset_req) rr_seen++;
      if (bus.nmi_timeout) nt_seen++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic frame_pulse();
    bus.frame_tick = 1'b1;
    @(negedge clk28);
    bus.frame_tick = 1'b0;
  endtask

  task automatic hotkey_pulse();
    bus.hotkey_req = 1'b1;
    @(negedge clk28);
    bus.hotkey_req = 1'b0;
  endtask

  initial begin
    int n, hi, base, hold;
    bit saw;
    bus.button_raw = 1'b0;
    bus.hotkey_req = 1'b0;
    bus.frame_tick = 1'b0;
    bus.magic_mode = 1'b0;
    rst = 1'b1;
    cycles(3);
    chk_en = 1'b1;
    check_eq("rst_magic_button", bus.magic_button, 0);
    check_eq("rst_reset_req", bus.reset_req, 0);
    check_eq("rst_nmi_timeout", bus.nmi_timeout, 0);
    check_eq("rst_busy", bus.busy, 0);
    rst = 1'b0;
    cycles(2);

    // Short glitch must not get through the debouncer
    bus.button_raw = 1'b1;
    cycles(5);
    bus.button_raw = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk28);
      if (bus.magic_button || dut.btn_db) saw = 1'b1;
    end
    check_eq("glitch_ignored", saw, 0);

    // Stable press: request appears 12 edges after the raw rising edge
    bus.button_raw = 1'b1;
    n = 0;
    while (!bus.magic_button && n < 40) begin
      @(negedge clk28);
      n++;
    end
    check_eq("press_latency", n, 12);

    // Long press inside magic mode
    bus.magic_mode = 1'b1;
    @(negedge clk28);
    check_eq("lp_hold_mb", bus.magic_button, 0);
    check_eq("lp_hold_busy", bus.busy, 1);
    base = rr_seen;
    frame_pulse(); cycles(2);
    frame_pulse(); cycles(2);
    frame_pulse();
    check_eq("lp_reset_req", bus.reset_req, 1);
    @(negedge clk28);
    check_eq("lp_reset_req_end", bus.reset_req, 0);
    for (int i = 0; i < 4; i++) begin frame_pulse(); cycles(1); end
    check_eq("lp_single_pulse", rr_seen - base, 1);
    check_eq("lp_busy_held", bus.busy, 1);
    bus.button_raw = 1'b0;
    bus.magic_mode = 1'b0;
    cycles(12);
    check_eq("lp_release_idle", bus.busy, 0);

    // Acknowledged hotkey request
    base = nt_seen;
    hi = 0;
    hotkey_pulse();
    for (int i = 0; i < 12; i++) begin
      if (bus.magic_button) hi++;
      if (i == 3) bus.magic_mode = 1'b1;
      @(negedge clk28);
    end
    check_eq("ack_mb_cycles", hi, 4);
    check_eq("ack_busy", bus.busy, 0);
    check_eq("ack_no_timeout", nt_seen - base, 0);
    bus.magic_mode = 1'b0;
    cycles(2);

    // Unanswered request times out
    base = nt_seen;
    hotkey_pulse();
    cycles(2);
    frame_pulse();
    check_eq("to_first_tick", bus.nmi_timeout, 0);
    cycles(1);
    frame_pulse();
    check_eq("to_pulse", bus.nmi_timeout, 1);
    check_eq("to_mb", bus.magic_button, 0);
    check_eq("to_busy", bus.busy, 0);
    cycles(1);
    check_eq("to_single", nt_seen - base, 1);

    // Hotkey coinciding with the debounced press, then tick with magic_mode
    base = nt_seen;
    bus.button_raw = 1'b1;
    cycles(11);
    hotkey_pulse();
    check_eq("sim_req_mb", bus.magic_button, 1);
    frame_pulse();
    bus.magic_mode = 1'b1;
    frame_pulse();
    check_eq("sim_hold_mb", bus.magic_button, 0);
    check_eq("sim_hold_busy", bus.busy, 1);
    check_eq("sim_no_timeout", nt_seen - base, 0);
    bus.button_raw = 1'b0;
    bus.magic_mode = 1'b0;
    cycles(14);
    check_eq("sim_idle", bus.busy, 0);

    // Reset while a request is pending
    hotkey_pulse();
    check_eq("mrst_req", bus.magic_button, 1);
    rst = 1'b1;
    @(negedge clk28);
    rst = 1'b0;
    check_eq("mrst_mb", bus.magic_button, 0);
    check_eq("mrst_busy", bus.busy, 0);
    check_eq("mrst_frame_cnt", dut.frame_cnt, 0);
    check_eq("mrst_db_cnt", dut.db_cnt, 0);
    cycles(3);

    // Randomized traffic against the model
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        bus.button_raw = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 30);
      end else begin
        hold--;
      end
      bus.hotkey_req = ($urandom_range(0, 15) == 0);
      bus.frame_tick = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) bus.magic_mode = ~bus.magic_mode;
      rst = ($urandom_range(0, 599) == 0);
      @(negedge clk28);
    end
    bus.button_raw = 1'b0;
    bus.hotkey_req = 1'b0;
    bus.frame_tick = 1'b0;
    bus.magic_mode = 1'b0;
    rst = 1'b0;
    cycles(20);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
